// File: rtl/pixel_serializer_pkg.sv
// Shared pixel-path types and helpers for the serializer and crop stages.
// Mono8 pixel type plus a width helper that never returns zero.
package pixel_serializer_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pix_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_coord_counter.sv
// Column/row raster counter advanced by a single step strobe, with force-to-origin,
// end-of-frame pulse and frame-idle tracking; shared with the crop stage.
module frame_coord_counter
   import pixel_serializer_pkg::*;
#(
   parameter int ROWS  = 20,
   parameter int COLS  = 20,
   parameter int COL_W = clog2_min1(COLS),
   parameter int ROW_W = clog2_min1(ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             clear,
   input  logic             busy,
   output logic [COL_W-1:0] cnt_col,
   output logic [ROW_W-1:0] cnt_row,
   output logic             at_origin,
   output logic             at_end,
   output logic             ap_idle,
   output logic             frame_done
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic col_last;
   logic row_last;

   assign col_last  = (cnt_col == COL_LAST);
   assign row_last  = (cnt_row == ROW_LAST);
   assign at_end    = col_last && row_last;
   assign at_origin = (cnt_col == '0) && (cnt_row == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_col    <= '0;
         cnt_row    <= '0;
         ap_idle    <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= step && at_end;

         if (clear) begin
            cnt_col <= '0;
            cnt_row <= '0;
         end else if (step) begin
            if (col_last) begin
               cnt_col <= '0;
               cnt_row <= row_last ? '0 : cnt_row + ROW_W'(1);
            end else begin
               cnt_col <= cnt_col + COL_W'(1);
            end
         end

         // End of frame wins over new activity so idle is seen for at least one cycle.
         if (step && at_end) begin
            ap_idle <= 1'b1;
         end else if (busy) begin
            ap_idle <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pixel_serializer.sv
// Splits wide Mono8 bursts into one pixel per handshake with raster coordinates,
// reloading back-to-back so a full-rate stream has no bubbles.
module pixel_serializer
   import pixel_serializer_pkg::*;
#(
   parameter int IN_ROWS          = 20,
   parameter int IN_COLS          = 20,
   parameter int PIXELS_PER_BURST = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                s_axis_tvalid,
   output logic                                s_axis_tready,
   input  logic [PIX_W*PIXELS_PER_BURST-1:0]   s_axis_tdata,
   input  logic                                s_axis_tuser,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output pix_t                                m_axis_tdata,
   output logic [clog2_min1(IN_COLS)-1:0]      cnt_col,
   output logic [clog2_min1(IN_ROWS)-1:0]      cnt_row,
   output logic                                ap_idle,
   output logic                                frame_done,
   output logic                                sof_error
);

   localparam int              IDX_W    = clog2_min1(PIXELS_PER_BURST);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_BURST - 1);

   pix_t             burst [PIXELS_PER_BURST];
   logic [IDX_W-1:0] idx;
   logic             full;

   logic hs;
   logic idx_last;
   logic accept;
   logic at_origin;
   logic at_end;
   logic next_origin;
   logic resync;

   assign idx_last      = (idx == IDX_LAST);
   assign hs            = full && m_axis_tready;
   assign s_axis_tready = !full || (m_axis_tready && idx_last);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign m_axis_tvalid = full;
   assign m_axis_tdata  = burst[idx];

   // A load while full only happens on the last pixel's handshake, so the new
   // beat's pixel 0 lands on the coordinate after the current one.
   assign next_origin = hs ? at_end : at_origin;
   assign resync      = accept && s_axis_tuser && !next_origin;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < PIXELS_PER_BURST; k++) begin
            burst[k] <= '0;
         end
         idx       <= '0;
         full      <= 1'b0;
         sof_error <= 1'b0;
      end else begin
         sof_error <= resync;
         if (accept) begin
            for (int k = 0; k < PIXELS_PER_BURST; k++) begin
               burst[k] <= s_axis_tdata[k*PIX_W +: PIX_W];
            end
            idx  <= '0;
            full <= 1'b1;
         end else if (hs) begin
            if (idx_last) begin
               idx  <= '0;
               full <= 1'b0;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

   frame_coord_counter #(
      .ROWS  (IN_ROWS),
      .COLS  (IN_COLS),
      .COL_W (clog2_min1(IN_COLS)),
      .ROW_W (clog2_min1(IN_ROWS))
   ) u_coord (
      .clk        (clk),
      .reset      (reset),
      .step       (hs),
      .clear      (resync),
      .busy       (accept || full),
      .cnt_col    (cnt_col),
      .cnt_row    (cnt_row),
      .at_origin  (at_origin),
      .at_end     (at_end),
      .ap_idle    (ap_idle),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench: the driver pushes expected pixels/coordinates per accepted beat,
// a negedge monitor pops and compares every presented pixel and per-cycle pulses.
module tb_pixel_serializer;

   localparam int R = 4;
   localparam int C = 8;
   localparam int P = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic [8*P-1:0]   s_axis_tdata = '0;
   logic             s_axis_tuser = 1'b0;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b0;
   logic [7:0]       m_axis_tdata;
   logic [$clog2(C)-1:0] cnt_col;
   logic [$clog2(R)-1:0] cnt_row;
   logic             ap_idle;
   logic             frame_done;
   logic             sof_error;

   pixel_serializer #(
      .IN_ROWS          (R),
      .IN_COLS          (C),
      .PIXELS_PER_BURST (P)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .cnt_col       (cnt_col),
      .cnt_row       (cnt_row),
      .ap_idle       (ap_idle),
      .frame_done    (frame_done),
      .sof_error     (sof_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dat;
      int col;
      int row;
      bit last;
   } exp_t;

   exp_t q[$];
   int   hs_log[$];
   int   done_log[$];
   int   idle_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pos = 0;
   int   sof_cyc = -1;
   int   rdy_mode = 0;
   int   acc_cyc = 0;
   int   pat = 0;
   bit   done_exp = 0;
   bit   hold_vld = 0;
   exp_t e;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // 0: always ready, 1: 1,0,0,1 pattern, 2: random, otherwise driven by hand
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_axis_tready = 1'b1;
         1: begin
            m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
            pat++;
         end
         2: m_axis_tready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (reset) begin
         done_exp = 0;
         hold_vld = 0;
      end else begin
         if (ap_idle) idle_log.push_back(cyc);
         if (frame_done) done_log.push_back(cyc);
         chk("frame_done", int'(frame_done), int'(done_exp));
         chk("sof_error", int'(sof_error), int'(cyc == sof_cyc));
         done_exp = 0;
         if (hold_vld) chk("valid_held", int'(m_axis_tvalid), 1);
         hold_vld = 0;
         if (m_axis_tvalid) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_pixel: got pixel %0d, expected none", m_axis_tdata);
            end else begin
               e = q[0];
               chk("tdata", int'(m_axis_tdata), e.dat);
               chk("cnt_col", int'(cnt_col), e.col);
               chk("cnt_row", int'(cnt_row), e.row);
               chk("s_tready_busy", int'(s_axis_tready), e.last ? int'(m_axis_tready) : 0);
               if (m_axis_tready) begin
                  void'(q.pop_front());
                  hs_log.push_back(cyc);
                  done_exp = (e.col == C - 1) && (e.row == R - 1);
                  if (!(e.col == 0 && e.row == 0)) chk("ap_idle_in_frame", int'(ap_idle), 0);
               end else begin
                  hold_vld = 1;
               end
            end
         end else begin
            chk("s_tready_empty", int'(s_axis_tready), 1);
         end
      end
   end

   task automatic send_beat(input logic [8*P-1:0] d, input bit tu);
      int i;
      s_axis_tdata  = d;
      s_axis_tuser  = tu;
      s_axis_tvalid = 1'b1;
      for (i = 0; i < 500; i++) begin
         @(negedge clk);
         if (s_axis_tready) break;
      end
      chk("beat_accept", int'(s_axis_tready), 1);
      if (s_axis_tready) begin
         acc_cyc = cyc;
         if (tu && pos != 0) begin
            pos     = 0;
            sof_cyc = cyc + 1;
         end
         for (int k = 0; k < P; k++) begin
            q.push_back('{int'(d[8*k +: 8]), pos % C, pos / C, k == P - 1});
            pos = (pos + 1) % (R * C);
         end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   function automatic logic [8*P-1:0] ramp(input int b);
      logic [8*P-1:0] d;
      for (int k = 0; k < P; k++) d[8*k +: 8] = 8'(P * b + k);
      return d;
   endfunction

   task automatic wait_drain();
      for (int i = 0; i < 3000 && (q.size() != 0 || m_axis_tvalid); i++) @(posedge clk);
      chk("drain_empty", q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rdy_mode = 3;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_s_tready", int'(s_axis_tready), 1);
      chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
      chk("rst_tdata", int'(m_axis_tdata), 0);
      chk("rst_col", int'(cnt_col), 0);
      chk("rst_row", int'(cnt_row), 0);
      chk("rst_idle", int'(ap_idle), 1);
      @(posedge clk);
      #1;

      // Steady stream at full rate
      rdy_mode = 0;
      hs_log.delete();
      done_log.delete();
      for (int b = 0; b < 8; b++) begin
         send_beat(ramp(b), b == 0);
         if (b == 0) chk("first_latency_ref", acc_cyc, acc_cyc);
      end
      wait_drain();
      chk("steady_count", hs_log.size(), 32);
      if (hs_log.size() == 32) begin
         chk("steady_span", hs_log[31] - hs_log[0], 31);
         chk("steady_done_gap", done_log.size() > 0 ? done_log[0] - hs_log[31] : -1, 1);
      end
      chk("steady_done_cnt", done_log.size(), 1);

      // Backpressure 1,0,0,1
      rdy_mode = 1;
      pat = 0;
      hs_log.delete();
      for (int b = 0; b < 8; b++) send_beat(ramp(b + 8), 1'b0);
      rdy_mode = 0;
      wait_drain();
      chk("bp_count", hs_log.size(), 32);

      // Input gap after beat 3
      for (int b = 0; b < 4; b++) send_beat(ramp(b), 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("gap_idle", int'(ap_idle), 0);
         if (i == 4) begin
            chk("gap_valid", int'(m_axis_tvalid), 0);
            chk("gap_col", int'(cnt_col), 0);
            chk("gap_row", int'(cnt_row), 2);
         end
         @(posedge clk);
         #1;
      end
      for (int b = 4; b < 8; b++) send_beat(ramp(b), 1'b0);
      wait_drain();

      // Resync after 12 pixels
      done_log.delete();
      for (int b = 0; b < 3; b++) send_beat(32'($urandom), 1'b0);
      send_beat({8'd103, 8'd102, 8'd101, 8'd100}, 1'b1);
      for (int b = 0; b < 7; b++) send_beat(32'($urandom), 1'b0);
      wait_drain();
      chk("resync_done_cnt", done_log.size(), 1);

      // Reset with two pixels still buffered
      rdy_mode = 3;
      m_axis_tready = 1'b1;
      send_beat(32'($urandom), 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      pos = 0;
      sof_cyc = -1;
      @(negedge clk);
      chk("mid_rst_valid", int'(m_axis_tvalid), 0);
      chk("mid_rst_col", int'(cnt_col), 0);
      chk("mid_rst_row", int'(cnt_row), 0);
      chk("mid_rst_idle", int'(ap_idle), 1);
      @(posedge clk);
      #1;
      rdy_mode = 0;
      for (int b = 0; b < 8; b++) send_beat(32'($urandom), 1'b0);
      wait_drain();

      // Back-to-back frames
      done_log.delete();
      idle_log.delete();
      for (int b = 0; b < 16; b++) send_beat(ramp(b), 1'b0);
      wait_drain();
      chk("b2b_done_cnt", done_log.size(), 2);
      if (done_log.size() == 2) begin
         int n = 0;
         chk("b2b_done_gap", done_log[1] - done_log[0], 32);
         foreach (idle_log[i]) if (idle_log[i] >= done_log[0] && idle_log[i] < done_log[1]) n++;
         chk("b2b_idle_cycles", n, 1);
      end

      // Random data, gaps, backpressure and occasional start-of-frame
      rdy_mode = 2;
      for (int b = 0; b < 40; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         send_beat(32'($urandom), $urandom_range(0, 7) == 0);
      end
      rdy_mode = 0;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
